// File: rtl/sram_bus_pkg.sv
// Shared types and constants for the sram-bus master arbiter.
package sram_bus_pkg;

    localparam int TYPE_W   = 4;
    localparam int STRB_W   = 16;
    localparam int LINE_OFF = 4;

    localparam int MST_ICACHE = 0;
    localparam int MST_DCACHE = 1;
    localparam int MST_LSU    = 2;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } r_state_e;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_ADDR = 1'b1
    } w_state_e;

endpackage

// File: rtl/sram_bus_arb_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] k;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < N; i++) begin
            k = IDX_W'((int'(ptr) + i) % N);
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = k;
            end
        end
    end

endmodule

// File: rtl/sram_bus_arb.sv
// Arbitrates N sram-bus masters onto one slave port; read and write channels
// are granted independently, round-robin, with a same-line read-after-write block.
//
// state  | meaning
// R_IDLE | no read granted; pick next winner from r_ptr
// R_ADDR | winner r_gnt presented to slave (held off while hazard)
// R_DATA | read accepted; waiting for s_re_valid
// W_IDLE | no write granted; pick next winner from w_ptr
// W_ADDR | winner w_gnt presented to slave until accepted or aborted
module sram_bus_arb #(
    parameter int N_MST  = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int STRB_W = 16,
    parameter int TYPE_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_MST-1:0]           m_r_req,
    input  logic [N_MST*ADDR_W-1:0]    m_r_addr,
    input  logic [N_MST*TYPE_W-1:0]    m_r_type,
    output logic [N_MST-1:0]           m_r_rdy,
    output logic [DATA_W-1:0]          m_re_data,
    output logic [N_MST-1:0]           m_re_valid,
    input  logic [N_MST-1:0]           m_w_req,
    input  logic [N_MST*ADDR_W-1:0]    m_w_addr,
    input  logic [N_MST*DATA_W-1:0]    m_w_data,
    input  logic [N_MST*TYPE_W-1:0]    m_w_type,
    input  logic [N_MST*STRB_W-1:0]    m_w_strb,
    output logic [N_MST-1:0]           m_w_rdy,
    output logic                       s_r_req,
    output logic [ADDR_W-1:0]          s_r_addr,
    output logic [TYPE_W-1:0]          s_r_type,
    input  logic                       s_r_rdy,
    input  logic [DATA_W-1:0]          s_re_data,
    input  logic                       s_re_valid,
    output logic                       s_w_req,
    output logic [ADDR_W-1:0]          s_w_addr,
    output logic [DATA_W-1:0]          s_w_data,
    output logic [TYPE_W-1:0]          s_w_type,
    output logic [STRB_W-1:0]          s_w_strb,
    input  logic                       s_w_rdy
);
    import sram_bus_pkg::*;

    localparam int IDX_W = (N_MST > 1) ? $clog2(N_MST) : 1;

    r_state_e         r_state, r_state_nxt;
    w_state_e         w_state, w_state_nxt;
    logic [IDX_W-1:0] r_gnt, r_gnt_nxt, r_ptr, r_ptr_nxt;
    logic [IDX_W-1:0] w_gnt, w_gnt_nxt, w_ptr, w_ptr_nxt;
    logic [IDX_W-1:0] r_pick_idx, w_pick_idx;
    logic [N_MST-1:0] r_pick_oh, w_pick_oh;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic             hazard;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(N_MST - 1)) ? '0 : i + 1'b1;
    endfunction

    rr_pick #(.N(N_MST), .IDX_W(IDX_W)) u_r_pick (
        .req (m_r_req),
        .ptr (r_ptr),
        .gnt (r_pick_oh),
        .idx (r_pick_idx)
    );

    rr_pick #(.N(N_MST), .IDX_W(IDX_W)) u_w_pick (
        .req (m_w_req),
        .ptr (w_ptr),
        .gnt (w_pick_oh),
        .idx (w_pick_idx)
    );

    assign r_addr = m_r_addr[r_gnt*ADDR_W +: ADDR_W];
    assign w_addr = m_w_addr[w_gnt*ADDR_W +: ADDR_W];

    // Only a write actually being offered to the slave can block a read.
    assign hazard = (w_state == W_ADDR) && s_w_req &&
                    (r_addr[ADDR_W-1:LINE_OFF] == w_addr[ADDR_W-1:LINE_OFF]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            r_gnt   <= '0;
            r_ptr   <= '0;
            w_state <= W_IDLE;
            w_gnt   <= '0;
            w_ptr   <= '0;
        end else begin
            r_state <= r_state_nxt;
            r_gnt   <= r_gnt_nxt;
            r_ptr   <= r_ptr_nxt;
            w_state <= w_state_nxt;
            w_gnt   <= w_gnt_nxt;
            w_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        r_state_nxt = r_state;
        r_gnt_nxt   = r_gnt;
        r_ptr_nxt   = r_ptr;
        s_r_req     = 1'b0;
        s_r_addr    = '0;
        s_r_type    = '0;
        m_r_rdy     = '0;
        m_re_valid  = '0;
        m_re_data   = '0;
        case (r_state)
            R_IDLE: begin
                if (|r_pick_oh) begin
                    r_gnt_nxt   = r_pick_idx;
                    r_state_nxt = R_ADDR;
                end
            end
            R_ADDR: begin
                s_r_req        = m_r_req[r_gnt] && !hazard;
                s_r_addr       = r_addr;
                s_r_type       = m_r_type[r_gnt*TYPE_W +: TYPE_W];
                m_r_rdy[r_gnt] = s_r_req && s_r_rdy;
                if (!m_r_req[r_gnt]) begin
                    r_state_nxt = R_IDLE;
                end else if (s_r_req && s_r_rdy) begin
                    r_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                m_re_valid[r_gnt] = s_re_valid;
                m_re_data         = s_re_data;
                if (s_re_valid) begin
                    r_state_nxt = R_IDLE;
                    r_ptr_nxt   = next_idx(r_gnt);
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_nxt = w_state;
        w_gnt_nxt   = w_gnt;
        w_ptr_nxt   = w_ptr;
        s_w_req     = 1'b0;
        s_w_addr    = '0;
        s_w_data    = '0;
        s_w_type    = '0;
        s_w_strb    = '0;
        m_w_rdy     = '0;
        case (w_state)
            W_IDLE: begin
                if (|w_pick_oh) begin
                    w_gnt_nxt   = w_pick_idx;
                    w_state_nxt = W_ADDR;
                end
            end
            W_ADDR: begin
                s_w_req        = m_w_req[w_gnt];
                s_w_addr       = w_addr;
                s_w_data       = m_w_data[w_gnt*DATA_W +: DATA_W];
                s_w_type       = m_w_type[w_gnt*TYPE_W +: TYPE_W];
                s_w_strb       = m_w_strb[w_gnt*STRB_W +: STRB_W];
                m_w_rdy[w_gnt] = s_w_req && s_w_rdy;
                if (!m_w_req[w_gnt]) begin
                    w_state_nxt = W_IDLE;
                end else if (s_w_rdy) begin
                    w_state_nxt = W_IDLE;
                    w_ptr_nxt   = next_idx(w_gnt);
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_bus_arb.sv
// Self-checking bench for sram_bus_arb against a round-robin reference model.
module tb_sram_bus_arb;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int SW = 16;
    localparam int TW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    m_r_req, m_r_rdy, m_re_valid, m_w_req, m_w_rdy;
    logic [N*AW-1:0] m_r_addr, m_w_addr;
    logic [N*TW-1:0] m_r_type, m_w_type;
    logic [N*DW-1:0] m_w_data;
    logic [N*SW-1:0] m_w_strb;
    logic [DW-1:0]   m_re_data, s_re_data, s_w_data;
    logic            s_r_req, s_r_rdy, s_re_valid, s_w_req, s_w_rdy;
    logic [AW-1:0]   s_r_addr, s_w_addr;
    logic [TW-1:0]   s_r_type, s_w_type;
    logic [SW-1:0]   s_w_strb;

    int n_checks = 0;
    int n_fail   = 0;
    int mr_ptr   = 0;
    int mw_ptr   = 0;
    logic [N-1:0] rq, wq;

    sram_bus_arb dut (
        .clk(clk), .rst_n(rst_n),
        .m_r_req(m_r_req), .m_r_addr(m_r_addr), .m_r_type(m_r_type), .m_r_rdy(m_r_rdy),
        .m_re_data(m_re_data), .m_re_valid(m_re_valid),
        .m_w_req(m_w_req), .m_w_addr(m_w_addr), .m_w_data(m_w_data), .m_w_type(m_w_type),
        .m_w_strb(m_w_strb), .m_w_rdy(m_w_rdy),
        .s_r_req(s_r_req), .s_r_addr(s_r_addr), .s_r_type(s_r_type), .s_r_rdy(s_r_rdy),
        .s_re_data(s_re_data), .s_re_valid(s_re_valid),
        .s_w_req(s_w_req), .s_w_addr(s_w_addr), .s_w_data(s_w_data), .s_w_type(s_w_type),
        .s_w_strb(s_w_strb), .s_w_rdy(s_w_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Reference arbitration: first requester found scanning upward from ptr.
    function automatic int rr_winner(input logic [N-1:0] req, input int ptr);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (ptr + i) % N;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        m_r_req = '0; m_w_req = '0;
        s_r_rdy = 1'b0; s_re_valid = 1'b0; s_w_rdy = 1'b0; s_re_data = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        mr_ptr = 0; mw_ptr = 0;
        step;
    endtask

    task automatic rand_fields;
        for (int i = 0; i < N; i++) begin
            m_r_addr[i*AW +: AW] = $urandom & 32'h7fff_ffff;
            m_w_addr[i*AW +: AW] = $urandom | 32'h8000_0000;
            m_r_type[i*TW +: TW] = 4'($urandom);
            m_w_type[i*TW +: TW] = 4'($urandom);
            m_w_data[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
            m_w_strb[i*SW +: SW] = 16'($urandom);
        end
    endtask

    task automatic run_read(input int rdy_dly, input int vld_dly, input bit reraise,
                            input logic [DW-1:0] d, output int got);
        int w;
        logic [N-1:0]  oh;
        logic [AW-1:0] ea;
        logic [TW-1:0] et;
        w = rr_winner(rq, mr_ptr);
        oh = '0; oh[w] = 1'b1;
        got = -1;
        m_r_req = rq; #1;
        n_checks++;
        if (s_r_req !== 1'b0) begin n_fail++; $display("FAIL rd_idle_quiet: s_r_req=%b want 0", s_r_req); end
        step;
        ea = m_r_addr[w*AW +: AW];
        et = m_r_type[w*TW +: TW];
        n_checks++;
        if (s_r_req !== 1'b1 || s_r_addr !== ea || s_r_type !== et) begin
            n_fail++;
            $display("FAIL rd_addr_phase: req=%b addr=%h type=%h want 1 %h %h", s_r_req, s_r_addr, s_r_type, ea, et);
        end
        repeat (rdy_dly) begin
            n_checks++;
            if (m_r_rdy !== '0) begin n_fail++; $display("FAIL rd_early_rdy: m_r_rdy=%b want 000", m_r_rdy); end
            step;
        end
        s_r_rdy = 1'b1; #1;
        for (int i = 0; i < N; i++) if (m_r_rdy[i]) got = i;
        n_checks++;
        if (m_r_rdy !== oh) begin n_fail++; $display("FAIL rd_accept: m_r_rdy=%b want %b", m_r_rdy, oh); end
        step;
        s_r_rdy = 1'b0;
        if (!reraise) rq[w] = 1'b0;
        m_r_req = rq;
        repeat (vld_dly) begin
            n_checks++;
            if (m_re_valid !== '0) begin n_fail++; $display("FAIL rd_early_valid: m_re_valid=%b want 000", m_re_valid); end
            step;
        end
        s_re_data = d; s_re_valid = 1'b1; #1;
        n_checks++;
        if (m_re_valid !== oh || m_re_data !== d) begin
            n_fail++;
            $display("FAIL rd_data: valid=%b data=%h want %b %h", m_re_valid, m_re_data, oh, d);
        end
        step;
        s_re_valid = 1'b0; s_re_data = '0; m_r_req = '0;
        mr_ptr = (w + 1) % N;
        n_checks++;
        if (int'(dut.r_ptr) !== mr_ptr) begin n_fail++; $display("FAIL rd_ptr: r_ptr=%0d want %0d", dut.r_ptr, mr_ptr); end
    endtask

    task automatic run_write(input int rdy_dly);
        int w;
        logic [N-1:0] oh;
        w = rr_winner(wq, mw_ptr);
        oh = '0; oh[w] = 1'b1;
        m_w_req = wq; #1;
        n_checks++;
        if (s_w_req !== 1'b0) begin n_fail++; $display("FAIL wr_idle_quiet: s_w_req=%b want 0", s_w_req); end
        step;
        n_checks++;
        if (s_w_req !== 1'b1 || s_w_addr !== m_w_addr[w*AW +: AW] || s_w_data !== m_w_data[w*DW +: DW] ||
            s_w_type !== m_w_type[w*TW +: TW] || s_w_strb !== m_w_strb[w*SW +: SW]) begin
            n_fail++;
            $display("FAIL wr_fields: req=%b addr=%h strb=%h want master %0d addr=%h strb=%h",
                     s_w_req, s_w_addr, s_w_strb, w, m_w_addr[w*AW +: AW], m_w_strb[w*SW +: SW]);
        end
        repeat (rdy_dly) begin
            n_checks++;
            if (m_w_rdy !== '0) begin n_fail++; $display("FAIL wr_early_rdy: m_w_rdy=%b want 000", m_w_rdy); end
            step;
        end
        s_w_rdy = 1'b1; #1;
        n_checks++;
        if (m_w_rdy !== oh) begin n_fail++; $display("FAIL wr_accept: m_w_rdy=%b want %b", m_w_rdy, oh); end
        step;
        s_w_rdy = 1'b0; wq[w] = 1'b0; m_w_req = '0;
        mw_ptr = (w + 1) % N;
        n_checks++;
        if (int'(dut.w_ptr) !== mw_ptr) begin n_fail++; $display("FAIL wr_ptr: w_ptr=%0d want %0d", dut.w_ptr, mw_ptr); end
    endtask

    task automatic test_reset;
        rand_fields();
        apply_reset();
        n_checks++;
        if ({s_r_req, s_w_req, m_r_rdy, m_re_valid, m_w_rdy} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: s_r_req=%b s_w_req=%b r_rdy=%b re_valid=%b w_rdy=%b want all 0",
                     s_r_req, s_w_req, m_r_rdy, m_re_valid, m_w_rdy);
        end
        n_checks++;
        if (s_r_addr !== '0 || s_w_addr !== '0 || s_w_data !== '0 || m_re_data !== '0 || s_w_strb !== '0) begin
            n_fail++; $display("FAIL reset_buses: s_r_addr=%h s_w_addr=%h want 0", s_r_addr, s_w_addr);
        end
        n_checks++;
        if (dut.r_ptr !== 2'd0 || dut.w_ptr !== 2'd0 || dut.r_gnt !== 2'd0 || dut.w_gnt !== 2'd0) begin
            n_fail++; $display("FAIL reset_regs: r_ptr=%0d w_ptr=%0d want 0 0", dut.r_ptr, dut.w_ptr);
        end
    endtask

    task automatic test_abort;
        m_r_req = 3'b001; step;
        n_checks++;
        if (s_r_req !== 1'b1) begin n_fail++; $display("FAIL abort_addr: s_r_req=%b want 1", s_r_req); end
        m_r_req = 3'b000; #1;
        n_checks++;
        if (s_r_req !== 1'b0) begin n_fail++; $display("FAIL abort_drop: s_r_req=%b want 0", s_r_req); end
        s_r_rdy = 1'b1; #1;
        n_checks++;
        if (m_r_rdy !== 3'b000) begin n_fail++; $display("FAIL abort_rdy: m_r_rdy=%b want 000", m_r_rdy); end
        step;
        s_r_rdy = 1'b0; s_re_valid = 1'b1; s_re_data = {4{32'hdead_beef}}; #1;
        n_checks++;
        if (dut.r_state !== sram_bus_pkg::R_IDLE || int'(dut.r_ptr) !== mr_ptr) begin
            n_fail++; $display("FAIL abort_state: state=%0d r_ptr=%0d want 0 %0d", dut.r_state, dut.r_ptr, mr_ptr);
        end
        repeat (2) begin
            n_checks++;
            if (m_re_valid !== 3'b000) begin n_fail++; $display("FAIL abort_valid: m_re_valid=%b want 000", m_re_valid); end
            step;
        end
        s_re_valid = 1'b0; s_re_data = '0;
    endtask

    task automatic test_single_read;
        int got;
        m_r_addr[1*AW +: AW] = 32'h8000_0040;
        rq = 3'b010;
        run_read(1, 2, 1'b0, {16{8'hA5}}, got);
        n_checks++;
        if (mr_ptr != 2 || got != 1) begin n_fail++; $display("FAIL single_read: granted %0d ptr %0d want 1 2", got, mr_ptr); end
    endtask

    task automatic test_contention;
        int got;
        int exp_order[4] = '{0, 1, 2, 0};
        apply_reset();
        rq = 3'b111;
        for (int k = 0; k < 4; k++) begin
            run_read(0, 0, 1'b1, {$urandom, $urandom, $urandom, $urandom}, got);
            n_checks++;
            if (got != exp_order[k]) begin n_fail++; $display("FAIL contention_order[%0d]: granted %0d want %0d", k, got, exp_order[k]); end
        end
    endtask

    task automatic test_hazard;
        m_r_addr[0*AW +: AW] = 32'h8000_1000;
        m_w_addr[1*AW +: AW] = 32'h8000_1008;
        m_w_req = 3'b010; m_r_req = 3'b001; s_w_rdy = 1'b0;
        step;
        repeat (4) begin
            n_checks++;
            if (s_r_req !== 1'b0 || s_w_req !== 1'b1) begin
                n_fail++; $display("FAIL hazard_block: s_r_req=%b s_w_req=%b want 0 1", s_r_req, s_w_req);
            end
            step;
        end
        s_w_rdy = 1'b1; #1;
        n_checks++;
        if (m_w_rdy !== 3'b010 || s_r_req !== 1'b0) begin
            n_fail++; $display("FAIL hazard_waccept: m_w_rdy=%b s_r_req=%b want 010 0", m_w_rdy, s_r_req);
        end
        step;
        s_w_rdy = 1'b0; m_w_req = '0; mw_ptr = 2; #1;
        n_checks++;
        if (s_r_req !== 1'b1 || s_r_addr !== 32'h8000_1000) begin
            n_fail++; $display("FAIL hazard_release: s_r_req=%b addr=%h want 1 80001000", s_r_req, s_r_addr);
        end
        s_r_rdy = 1'b1; step;
        s_r_rdy = 1'b0; m_r_req = '0; s_re_valid = 1'b1; step;
        s_re_valid = 1'b0; mr_ptr = 1;
        m_r_addr[0*AW +: AW] = 32'h8000_2000;
        m_w_req = 3'b010; m_r_req = 3'b001;
        step;
        n_checks++;
        if (s_r_req !== 1'b1 || s_w_req !== 1'b1) begin
            n_fail++; $display("FAIL hazard_other_line: s_r_req=%b s_w_req=%b want 1 1", s_r_req, s_w_req);
        end
        s_r_rdy = 1'b1; s_w_rdy = 1'b1; #1;
        n_checks++;
        if (m_r_rdy !== 3'b001 || m_w_rdy !== 3'b010) begin
            n_fail++; $display("FAIL hazard_other_accept: r_rdy=%b w_rdy=%b want 001 010", m_r_rdy, m_w_rdy);
        end
        step;
        s_r_rdy = 1'b0; s_w_rdy = 1'b0; m_r_req = '0; m_w_req = '0; s_re_valid = 1'b1; #1;
        n_checks++;
        if (m_re_valid !== 3'b001) begin n_fail++; $display("FAIL hazard_other_data: m_re_valid=%b want 001", m_re_valid); end
        step;
        s_re_valid = 1'b0; mr_ptr = 1; mw_ptr = 2;
    endtask

    task automatic test_concurrent;
        int got;
        m_r_addr[0*AW +: AW] = 32'h8000_0000;
        m_w_addr[2*AW +: AW] = 32'h8000_0100;
        rq = 3'b001; wq = 3'b100;
        fork
            run_read(0, 1, 1'b0, {$urandom, $urandom, $urandom, $urandom}, got);
            run_write(0);
        join
    endtask

    task automatic test_random;
        int got;
        for (int it = 0; it < 20; it++) begin
            rand_fields();
            rq = 3'($urandom_range(1, 7));
            wq = 3'($urandom_range(1, 7));
            fork
                run_read($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                         {$urandom, $urandom, $urandom, $urandom}, got);
                run_write($urandom_range(0, 3));
            join
        end
    endtask

    task automatic test_reset_mid;
        int got;
        m_r_req = 3'b001; step;
        s_r_rdy = 1'b1; step;
        s_r_rdy = 1'b0; s_re_valid = 1'b1; s_re_data = {4{$urandom}}; #1;
        n_checks++;
        if (dut.r_state !== sram_bus_pkg::R_DATA) begin n_fail++; $display("FAIL rstmid_setup: state=%0d want 2", dut.r_state); end
        rst_n = 1'b0; #1;
        n_checks++;
        if ({s_r_req, s_w_req, m_r_rdy, m_re_valid, m_w_rdy} !== '0 || m_re_data !== '0 || s_r_addr !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs: re_valid=%b re_data=%h s_r_req=%b want 0", m_re_valid, m_re_data, s_r_req);
        end
        m_r_req = '0; s_re_valid = 1'b0; s_re_data = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        mr_ptr = 0; mw_ptr = 0;
        step;
        n_checks++;
        if (dut.r_ptr !== 2'd0) begin n_fail++; $display("FAIL rstmid_ptr: r_ptr=%0d want 0", dut.r_ptr); end
        rq = 3'b111;
        run_read(0, 0, 1'b0, {$urandom, $urandom, $urandom, $urandom}, got);
        n_checks++;
        if (got != 0) begin n_fail++; $display("FAIL rstmid_grant: granted %0d want 0", got); end
    endtask

    initial begin
        rst_n = 1'b0;
        m_r_req = '0; m_w_req = '0; s_r_rdy = 1'b0; s_w_rdy = 1'b0;
        s_re_valid = 1'b0; s_re_data = '0;
        rq = '0; wq = '0;
        test_reset();
        test_abort();
        test_single_read();
        test_contention();
        test_hazard();
        test_concurrent();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_bus_arb.md
Name: sram_bus_arb

Overview:
- Arbitrates N sram-bus masters (icache refill, dcache refill/writeback, lsu uncached) onto the single sram-bus slave port that feeds mem2axi.
- Read and write channels are arbitrated independently, each round-robin.
- Exactly one read is outstanding at a time, held from grant until its data return.
- A read is blocked while an in-flight write targets the same 16-byte line (read-after-write ordering).

Parameters:
N_MST, 3, number of masters; index 0 = icache, 1 = dcache, 2 = lsu
ADDR_W, 32, address width
DATA_W, 128, line data width
STRB_W, 16, byte strobe width (DATA_W/8)
TYPE_W, 4, transfer type field; passed through opaque
LINE_OFF, 4, low address bits ignored by the line-hazard compare

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
m_r_req  in  N_MST  per-master read request
m_r_addr  in  N_MST*ADDR_W  per-master read address
m_r_type  in  N_MST*TYPE_W  per-master read type
m_r_rdy  out  N_MST  read request accepted (one-hot)
m_re_data  out  DATA_W  read data, broadcast to all masters
m_re_valid  out  N_MST  read data valid (one-hot)
m_w_req  in  N_MST  per-master write request
m_w_addr  in  N_MST*ADDR_W  write address
m_w_data  in  N_MST*DATA_W  write data
m_w_type  in  N_MST*TYPE_W  write type
m_w_strb  in  N_MST*STRB_W  write byte strobes
m_w_rdy  out  N_MST  write accepted (one-hot)
s_r_req  out  1  slave read request
s_r_addr  out  ADDR_W  slave read address
s_r_type  out  TYPE_W  slave read type
s_r_rdy  in  1  slave accepted the read
s_re_data  in  DATA_W  slave read data
s_re_valid  in  1  slave read data valid
s_w_req  out  1  slave write request
s_w_addr  out  ADDR_W  slave write address
s_w_data  out  DATA_W  slave write data
s_w_type  out  TYPE_W  slave write type
s_w_strb  out  STRB_W  slave write strobes
s_w_rdy  in  1  slave accepted the write

Behaviour:
- Handshake: a transfer occurs on the cycle where req and rdy are both high.
- Masters hold req and all fields stable until rdy.
- Read FSM states: R_IDLE, R_ADDR, R_DATA. Reset state R_IDLE.
  - R_IDLE: if any m_r_req is set, latch the round-robin winner into r_gnt (search starts at r_ptr) and go to R_ADDR. No downstream activity this cycle. Best latency is m_r_req at cycle t to s_r_req at t+1.
  - R_ADDR: s_r_req = m_r_req[r_gnt] && !hazard. Address and type are muxed combinationally from r_gnt. m_r_rdy[r_gnt] = s_r_rdy && s_r_req.
    - On accept, go to R_DATA.
    - If m_r_req[r_gnt] drops before accept (abort), go to R_IDLE with no slave transaction and r_ptr unchanged.
  - R_DATA: m_re_valid[r_gnt] = s_re_valid. m_re_data = s_re_data.
    - On s_re_valid, go to R_IDLE and set r_ptr = r_gnt+1 (mod N_MST).
    - Data is delivered even if that master has since dropped req.
    - Any s_re_valid outside R_DATA is ignored.
- Write FSM states: W_IDLE, W_ADDR. Reset state W_IDLE.
  - Same grant scheme using w_ptr and w_gnt.
  - W_ADDR forwards the granted master's fields. m_w_rdy[w_gnt] = s_w_rdy.
  - On accept, return to W_IDLE and set w_ptr = w_gnt+1.
  - A write abort (req drop) returns to W_IDLE with w_ptr unchanged.
- Hazard: hazard = (w_state==W_ADDR) && s_w_req && (r_addr[ADDR_W-1:LINE_OFF] == w_addr[ADDR_W-1:LINE_OFF]).
  - While hazard is set, s_r_req is held low.
  - The write is never stalled by a read.
- Simultaneous read and write grants are allowed; the two channels are independent.
- Round-robin example: with all masters requesting and r_ptr=1, the grant order is 1, 2, 0.
- Reset values: all outputs 0 (s_*_req, m_r_rdy, m_re_valid, m_w_rdy, data buses 0). r_ptr=0, w_ptr=0, r_gnt=0, w_gnt=0.
- Reset mid-operation: both FSMs return to idle immediately (asynchronous). Any in-flight slave response is dropped; the slave side is reset by the same rst_n.
- No outputs are 1 in idle states. All rdy/valid outputs are one-hot or zero.

Decomposition:
- Shared package sram_bus_pkg: read FSM state enum, write FSM state enum, TYPE_W/STRB_W/LINE_OFF constants, master index constants (MST_ICACHE=0, MST_DCACHE=1, MST_LSU=2).
- One natural sub-module: rr_pick (N-bit request vector plus pointer in, one-hot grant and encoded index out, purely combinational). Instantiated once per channel.

Test Plan:
1. Single read: m_r_req=3'b010, addr 0x8000_0040; slave gives rdy at t+2 and valid at t+5 with data 0xA5…A5.
   - s_r_req rises at t+1; m_r_rdy=3'b010 at t+2; m_re_valid=3'b010 at t+5 with matching data; r_ptr=2.
2. Contention: all three masters hold read req from reset; slave is zero-wait.
   - Grant order 0, 1, 2, 0; no master is granted twice before the others are served.
3. Read-after-write hazard: master1 write to 0x8000_1008 stalled (s_w_rdy=0 for 4 cycles) while master0 reads 0x8000_1000.
   - s_r_req stays 0 until the cycle after the write is accepted, then rises.
   - A concurrent read of 0x8000_2000 proceeds unblocked.
4. Abort: master0 raises r_req, then drops it in R_ADDR before s_r_rdy.
   - No slave accept occurs, FSM returns to R_IDLE, r_ptr stays 0, m_re_valid never asserts.
5. Concurrent channels: read from master0 and write from master2 in the same cycle, different lines.
   - Both s_r_req and s_w_req assert at t+1; m_w_rdy=3'b100 when s_w_rdy is high.
6. rst_n pulsed low in R_DATA.
   - All outputs go 0 asynchronously; after release, a new request is granted normally starting from r_ptr=0.
